// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit holding HI/LO for the MIPS E stage.
// Optional MDU_CANCEL_EN adds a Cancel input that flushes an in-flight op.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
`ifdef MDU_CANCEL_EN
    input  logic        Cancel,
`endif
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] Data1,
    input  logic [31:0] Data2,
    input  logic        HISel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

    state_t       state;
    logic [4:0]   cnt;
    logic [63:0]  hold;
    logic         hold_commit;
    logic         cancel;

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] a_mag;
    logic        [31:0] b_mag;
    logic        [31:0] b_mag_safe;
    logic        [31:0] b_u_safe;
    logic        [31:0] q_mag;
    logic        [31:0] r_mag;
    logic               div_zero;
    logic        [63:0] res;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

`ifdef MDU_CANCEL_EN
    assign cancel = Cancel;
`else
    assign cancel = 1'b0;
`endif

    assign a_sx   = {{32{Data1[31]}}, Data1};
    assign b_sx   = {{32{Data2[31]}}, Data2};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, Data1} * {32'd0, Data2};

    // Signed divide works on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        div_zero   = (Data2 == 32'd0);
        a_mag      = cond_neg(Data1, Data1[31]);
        b_mag      = cond_neg(Data2, Data2[31]);
        b_mag_safe = div_zero ? 32'd1 : b_mag;
        b_u_safe   = div_zero ? 32'd1 : Data2;
        q_mag      = a_mag / b_mag_safe;
        r_mag      = a_mag % b_mag_safe;
        res        = prod_s;
        case (MDOp[1:0])
            2'd0: res = prod_s;
            2'd1: res = prod_u;
            2'd2: res = {cond_neg(r_mag, Data1[31]), cond_neg(q_mag, Data1[31] ^ Data2[31])};
            2'd3: res = {Data1 % b_u_safe, Data1 / b_u_safe};
            default: res = prod_s;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= 5'd0;
            Busy        <= 1'b0;
            HI          <= 32'd0;
            LO          <= 32'd0;
            hold        <= 64'd0;
            hold_commit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start && !cancel) begin
                        case (MDOp)
                            3'd0, 3'd1: begin
                                hold        <= res;
                                hold_commit <= 1'b1;
                                cnt         <= MULT_N;
                                Busy        <= 1'b1;
                                state       <= BUSY;
                            end
                            3'd2, 3'd3: begin
                                hold        <= res;
                                hold_commit <= !div_zero;
                                cnt         <= DIV_N;
                                Busy        <= 1'b1;
                                state       <= BUSY;
                            end
                            3'd4: HI <= Data1;
                            3'd5: LO <= Data1;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    if (cancel) begin
                        state       <= IDLE;
                        cnt         <= 5'd0;
                        Busy        <= 1'b0;
                        hold_commit <= 1'b0;
                    end else begin
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd1) begin
                            if (hold_commit) begin
                                HI <= hold[63:32];
                                LO <= hold[31:0];
                            end
                            Busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign MDOut = HISel ? HI : LO;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: vector table through a scoreboard queue,
// plus hand-written sequences for back-to-back moves, ignored starts, reset and Cancel.
module tb_e_mdu;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] Data1;
    logic [31:0] Data2;
    logic        HISel;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDOut;
`ifdef MDU_CANCEL_EN
    logic        Cancel;
`endif

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk   (Clk),
        .Reset (Reset),
`ifdef MDU_CANCEL_EN
        .Cancel(Cancel),
`endif
        .Start (Start),
        .MDOp  (MDOp),
        .Data1 (Data1),
        .Data2 (Data2),
        .HISel (HISel),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO),
        .MDOut (MDOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    localparam int NV = 13;
    vec_t        vecs [NV];
    logic [63:0] sb_q [$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_hi = 32'd0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        int          n;
        logic [63:0] exp;
        @(negedge Clk);
        Start = 1'b1;
        MDOp  = vecs[i].op;
        Data1 = vecs[i].d1;
        Data2 = vecs[i].d2;
        HISel = 1'b0;
        sb_q.push_back({vecs[i].hi, vecs[i].lo});
        @(negedge Clk);
        Start = 1'b0;
        Data1 = $urandom;
        Data2 = $urandom;
        if (vecs[i].cyc > 0) check32($sformatf("v%0d_hi_during_busy", i), HI, prev_hi);
        n = 0;
        while (Busy && n < 64) begin
            n++;
            @(negedge Clk);
        end
        check32($sformatf("v%0d_busy_cycles", i), 32'(n), 32'(vecs[i].cyc));
        exp = sb_q.pop_front();
        check32($sformatf("v%0d_hi", i), HI, exp[63:32]);
        check32($sformatf("v%0d_lo", i), LO, exp[31:0]);
        HISel = 1'b1;
        #1 check32($sformatf("v%0d_mdout_hi", i), MDOut, exp[63:32]);
        HISel = 1'b0;
        #1 check32($sformatf("v%0d_mdout_lo", i), MDOut, exp[31:0]);
        prev_hi = exp[63:32];
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd3, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{3'd3, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 10};
        vecs[6]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[7]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[8]  = '{3'd2, 32'hFFFFFFF9, 32'h00000000, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[9]  = '{3'd4, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFD, 0};
        vecs[10] = '{3'd5, 32'hCAFEBABE, 32'h00000000, 32'h12345678, 32'hCAFEBABE, 0};
        vecs[11] = '{3'd6, 32'hDEADBEEF, 32'h00000001, 32'h12345678, 32'hCAFEBABE, 0};
        vecs[12] = '{3'd1, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 5};

        Reset = 1'b1;
        Start = 1'b0;
        MDOp  = 3'd0;
        Data1 = 32'd0;
        Data2 = 32'd0;
        HISel = 1'b0;
`ifdef MDU_CANCEL_EN
        Cancel = 1'b0;
`endif
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check32("reset_busy", 32'(Busy), 32'd0);
        check32("reset_hi", HI, 32'd0);
        check32("reset_lo", LO, 32'd0);
        check32("reset_mdout", MDOut, 32'd0);
        Reset = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i);

        // Back-to-back MTHI then MTLO.
        @(negedge Clk);
        Start = 1'b1; MDOp = 3'd4; Data1 = 32'hA1B2C3D4;
        @(negedge Clk);
        check32("mthi_hi", HI, 32'hA1B2C3D4);
        check32("mthi_busy", 32'(Busy), 32'd0);
        MDOp = 3'd5; Data1 = 32'h0BADF00D;
        @(negedge Clk);
        Start = 1'b0;
        check32("mtlo_lo", LO, 32'h0BADF00D);
        check32("mtlo_hi_kept", HI, 32'hA1B2C3D4);
        check32("mtlo_busy", 32'(Busy), 32'd0);

        // MULT start during a busy DIV is ignored.
        @(negedge Clk);
        Start = 1'b1; MDOp = 3'd2; Data1 = 32'd100; Data2 = 32'd7;
        @(negedge Clk);
        Start = 1'b0;
        n = 0;
        while (Busy && n < 64) begin
            n++;
            if (n == 2) begin
                Start = 1'b1; MDOp = 3'd0; Data1 = 32'd3; Data2 = 32'd4;
            end else begin
                Start = 1'b0;
            end
            @(negedge Clk);
        end
        Start = 1'b0;
        check32("ign_busy_cycles", 32'(n), 32'd10);
        check32("ign_hi", HI, 32'd2);
        check32("ign_lo", LO, 32'd14);
        @(negedge Clk);
        check32("ign_no_restart", 32'(Busy), 32'd0);

`ifdef MDU_CANCEL_EN
        @(negedge Clk);
        Start = 1'b1; MDOp = 3'd4; Data1 = 32'hAAAA5555;
        @(negedge Clk);
        MDOp = 3'd5; Data1 = 32'h5555AAAA;
        @(negedge Clk);
        MDOp = 3'd0; Data1 = 32'd3; Data2 = 32'd4;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        Cancel = 1'b1;
        @(negedge Clk);
        Cancel = 1'b0;
        check32("cancel_busy", 32'(Busy), 32'd0);
        repeat (8) @(negedge Clk);
        check32("cancel_hi", HI, 32'hAAAA5555);
        check32("cancel_lo", LO, 32'h5555AAAA);
        Start = 1'b1; Cancel = 1'b1; MDOp = 3'd0;
        @(negedge Clk);
        check32("cancel_start_busy", 32'(Busy), 32'd0);
        MDOp = 3'd5; Data1 = 32'h0;
        @(negedge Clk);
        Start = 1'b0; Cancel = 1'b0;
        check32("cancel_mtlo_lo", LO, 32'h5555AAAA);
        repeat (7) @(negedge Clk);
        check32("cancel_start_hi", HI, 32'hAAAA5555);
        check32("cancel_start_busy2", 32'(Busy), 32'd0);
`endif

        // Asynchronous reset in the middle of a DIV.
        @(negedge Clk);
        Start = 1'b1; MDOp = 3'd2; Data1 = 32'hFFFFFFF9; Data2 = 32'd2;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        check32("async_rst_busy", 32'(Busy), 32'd0);
        check32("async_rst_hi", HI, 32'd0);
        check32("async_rst_lo", LO, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (12) @(negedge Clk);
        check32("post_rst_busy", 32'(Busy), 32'd0);
        check32("post_rst_hi", HI, 32'd0);
        check32("post_rst_lo", LO, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
